c3po_egress_sf: RTL and testbench
=================================

# c3po_egress_sf

Per-port store-and-forward egress buffer that sits directly downstream of each C-3PO unpacker slice. It takes the unpacker's 32-byte beat stream (val/sop/eop/vbc/data, no backpressure available upstream) and stores it in a beat FIFO. It releases only complete packets to a valid/ready egress interface. Packets that overflow the buffer are dropped whole and counted, so the egress side never sees a truncated packet.

## Interface
- `DEPTH_P`, 16: FIFO depth in beats; power of 2, ≥2.
- `CNT_SIZE_P`, 8: width of the statistics counters.

- `clk`  in  1  single clock.
- `reset_L`  in  1  asynchronous active-low reset.
- `in_val`  in  1  beat valid (from unpacker `o_val`).
- `in_sop`  in  1  first beat of packet.
- `in_eop`  in  1  last beat of packet.
- `in_vbc`  in  8  valid bytes in beat, 1..32.
- `in_data`  in  256  beat payload.
- `out_val`  out  1  egress beat valid.
- `out_sop` / `out_eop`  out  1  egress packet delimiters.
- `out_vbc`  out  8  egress valid bytes.
- `out_data`  out  256  egress payload.
- `out_ready`  in  1  egress sink accepts beat.
- `drop_cnt`  out  CNT_SIZE_P  packets dropped on overflow; saturating.
- `pkt_cnt`  out  CNT_SIZE_P  committed packets fully egressed; wrapping.
- `proto_err`  out  1  one-cycle pulse on a framing violation.
- `idle`  out  1  FIFO empty and write FSM in IDLE.

## Operation
- Storage: DEPTH_P entries of {sop, eop, vbc[7:0], data[255:0]} (266 bits).
- Pointers are AW+1 bits wide, AW = log2(DEPTH_P), so wrap is detected by the MSB:
  - `wr_ptr`: speculative write position.
  - `cm_ptr`: end of the last committed packet.
  - `rd_ptr`: read position.
- Full condition: `wr_ptr - rd_ptr == DEPTH_P`, evaluated on the registered `rd_ptr`. A read in the same cycle does not free space for that cycle's write.
- Write FSM, states IDLE / WRITE / DROP:
  - IDLE, `in_val & in_sop`, not full: write beat. If `in_eop` is also set, commit (`cm_ptr <= wr_ptr+1`) and stay in IDLE; otherwise go to WRITE.
  - IDLE, `in_val & !in_sop`: discard the beat, pulse `proto_err`.
  - WRITE, `in_val & !in_sop`, not full: write beat. On `in_eop`, commit and go to IDLE.
  - WRITE, `in_val & in_sop` (missing eop): pulse `proto_err`, rewind `wr_ptr <= cm_ptr`, then handle the beat as a new sop from IDLE in the same cycle.
  - Any state, beat arrives while full: rewind `wr_ptr <= cm_ptr` and increment `drop_cnt` (saturating). Go to IDLE if the beat has `in_eop`, else go to DROP.
  - DROP: discard beats until an `in_eop` beat, then go to IDLE. A sop seen in DROP pulses `proto_err` and is handled as a new sop from IDLE.
- Any packet longer than DEPTH_P beats is always dropped.
- Read side:
  - `out_val = (rd_ptr != cm_ptr)`; `out_*` fields are driven combinationally from `mem[rd_ptr]` (show-ahead).
  - A transfer occurs when `out_val & out_ready`; it advances `rd_ptr`. An eop transfer increments `pkt_cnt`.
  - Beats are never visible before their packet is committed.
- `vbc` and `data` are passed through unmodified. `vbc` is not range-checked.

## Timing
- Reset values: `out_val`=0, `out_sop`=0, `out_eop`=0, `out_vbc`=0, `out_data`=0 (gated while empty), `drop_cnt`=0, `pkt_cnt`=0, `proto_err`=0, `idle`=1. All pointers 0, FSM in IDLE.
- Latency: an eop beat written at edge N makes `out_val`=1 for that packet's sop from cycle N+1. Minimum sop-in to sop-out latency is 1 cycle for a single-beat packet.
- Throughput: 1 beat/cycle in and out concurrently.
- `out_*` stay stable while `out_val & !out_ready`.
- Reset asserted mid-packet clears everything immediately. Partial and committed data are lost. After deassertion, the first accepted beat must carry sop.
- `proto_err` and a `drop_cnt` increment may occur in the same cycle.

## Structure
- Shared package `c3po_pkg`:
  - `beat_t` struct {sop, eop, vbc[7:0], data[255:0]}.
  - `BEAT_BYTES`=32.
  - Write-state enum `egr_wr_state_e`.
- One sub-module, `c3po_sf_mem`: a DEPTH_P × beat_t flop array with one write port and one async read port, no reset on data.
- Pointer logic, FSM and counters live in the top module.
- C-3PO instantiates one `c3po_egress_sf` per port on `o_*[i]`.

## Test plan
- 3-beat packet (vbc 32,32,5), `out_ready`=1 → `out_val` rises 1 cycle after the eop beat; beats egress in order with vbc 32,32,5; `pkt_cnt`=1.
- DEPTH_P=16, `out_ready`=0, send a 10-beat then an 8-beat packet → first packet held (10 beats); second dropped at its 7th beat; `drop_cnt`=1. After `out_ready`=1, exactly 10 beats egress.
- 20-beat packet with an empty FIFO → dropped; `drop_cnt`=1; `out_val` never asserts; `idle`=1 after eop.
- sop, 2 beats, then a new sop (missing eop) with 1-beat eop → `proto_err` pulse; only the 1-beat packet egresses.
- Mid-packet beat without a preceding sop, in IDLE → `proto_err` pulse; beat discarded; FIFO stays empty.
- Async reset asserted during the 2nd beat of a 4-beat packet → outputs zero immediately, counters 0. A following 1-beat packet egresses normally.

Source files
------------

// File: rtl/c3po_pkg.sv
// rtl/c3po_pkg.sv - shared types for the C-3PO egress store-and-forward buffer
package c3po_pkg;

  localparam int BEAT_BYTES = 32;

  typedef struct packed {
    logic                      sop;
    logic                      eop;
    logic [7:0]                vbc;
    logic [BEAT_BYTES*8-1:0]   data;
  } beat_t;

  typedef enum logic [1:0] {
    EGR_IDLE  = 2'd0,
    EGR_WRITE = 2'd1,
    EGR_DROP  = 2'd2
  } egr_wr_state_e;

endpackage

// File: rtl/c3po_sf_mem.sv
// rtl/c3po_sf_mem.sv - beat storage: one write port, one async read port, no data reset
module c3po_sf_mem
  import c3po_pkg::*;
#(
  parameter int DEPTH_P = 16,
  parameter int AW      = $clog2(DEPTH_P)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  beat_t         wdata,
  input  logic [AW-1:0] raddr,
  output beat_t         rdata
);

  beat_t mem [DEPTH_P];

  // Store one beat per cycle; contents are only meaningful between rd_ptr and wr_ptr
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/c3po_egress_sf.sv
// rtl/c3po_egress_sf.sv - per-port store-and-forward egress buffer with whole-packet drop
module c3po_egress_sf
  import c3po_pkg::*;
#(
  parameter int DEPTH_P    = 16,
  parameter int CNT_SIZE_P = 8
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    in_val,
  input  logic                    in_sop,
  input  logic                    in_eop,
  input  logic [7:0]              in_vbc,
  input  logic [255:0]            in_data,
  output logic                    out_val,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic [7:0]              out_vbc,
  output logic [255:0]            out_data,
  input  logic                    out_ready,
  output logic [CNT_SIZE_P-1:0]   drop_cnt,
  output logic [CNT_SIZE_P-1:0]   pkt_cnt,
  output logic                    proto_err,
  output logic                    idle
);

  localparam int            AW      = $clog2(DEPTH_P);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH_P);

  egr_wr_state_e state, state_nxt;
  logic [AW:0]   wr_ptr, wr_nxt;
  logic [AW:0]   cm_ptr, cm_nxt;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   base;
  logic          we;
  logic [AW-1:0] waddr;
  logic          perr;
  logic          drop_inc;
  logic          start_sop;
  logic          full_wr;
  logic          xfer;
  beat_t         wbeat;
  beat_t         rbeat;

  // Fullness is judged on the registered rd_ptr, so a same-cycle read never frees space
  assign full_wr = (wr_ptr - rd_ptr) == DEPTH_W;

  assign wbeat.sop  = in_sop;
  assign wbeat.eop  = in_eop;
  assign wbeat.vbc  = in_vbc;
  assign wbeat.data = in_data;

  // Write FSM: speculative writes, commit on eop, rewind to cm_ptr on overflow or missing eop
  always_comb begin
    state_nxt = state;
    wr_nxt    = wr_ptr;
    cm_nxt    = cm_ptr;
    we        = 1'b0;
    waddr     = wr_ptr[AW-1:0];
    perr      = 1'b0;
    drop_inc  = 1'b0;
    start_sop = 1'b0;
    base      = wr_ptr;
    if (in_val) begin
      unique case (state)
        EGR_IDLE: begin
          if (in_sop) start_sop = 1'b1;
          else        perr      = 1'b1;
        end
        EGR_WRITE: begin
          if (in_sop) begin
            // Previous packet never ended: discard it and restart from the committed point
            perr      = 1'b1;
            start_sop = 1'b1;
            base      = cm_ptr;
            wr_nxt    = cm_ptr;
          end else if (full_wr) begin
            wr_nxt    = cm_ptr;
            drop_inc  = 1'b1;
            state_nxt = in_eop ? EGR_IDLE : EGR_DROP;
          end else begin
            we     = 1'b1;
            wr_nxt = wr_ptr + 1'b1;
            if (in_eop) begin
              cm_nxt    = wr_ptr + 1'b1;
              state_nxt = EGR_IDLE;
            end
          end
        end
        EGR_DROP: begin
          // wr_ptr already equals cm_ptr here, so base needs no rewind
          if (in_sop) begin
            perr      = 1'b1;
            start_sop = 1'b1;
          end else if (in_eop) begin
            state_nxt = EGR_IDLE;
          end
        end
        default: state_nxt = EGR_IDLE;
      endcase
      if (start_sop) begin
        if ((base - rd_ptr) == DEPTH_W) begin
          wr_nxt    = cm_ptr;
          drop_inc  = 1'b1;
          state_nxt = in_eop ? EGR_IDLE : EGR_DROP;
        end else begin
          we     = 1'b1;
          waddr  = base[AW-1:0];
          wr_nxt = base + 1'b1;
          if (in_eop) begin
            cm_nxt    = base + 1'b1;
            state_nxt = EGR_IDLE;
          end else begin
            state_nxt = EGR_WRITE;
          end
        end
      end
    end
  end

  // Write-side state, pointers, drop counter and the registered framing-error pulse
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= EGR_IDLE;
      wr_ptr    <= '0;
      cm_ptr    <= '0;
      drop_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_nxt;
      cm_ptr    <= cm_nxt;
      proto_err <= perr;
      if (drop_inc && (drop_cnt != {CNT_SIZE_P{1'b1}})) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  c3po_sf_mem #(
    .DEPTH_P (DEPTH_P),
    .AW      (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wbeat),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rbeat)
  );

  // Only committed beats are visible; fields are forced to zero while nothing is committed
  assign out_val  = (rd_ptr != cm_ptr);
  assign out_sop  = out_val & rbeat.sop;
  assign out_eop  = out_val & rbeat.eop;
  assign out_vbc  = out_val ? rbeat.vbc  : 8'd0;
  assign out_data = out_val ? rbeat.data : 256'd0;
  assign xfer     = out_val & out_ready;
  assign idle     = (wr_ptr == rd_ptr) && (state == EGR_IDLE);

  // Read pointer and egressed-packet counter
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rd_ptr  <= '0;
      pkt_cnt <= '0;
    end else if (xfer) begin
      rd_ptr <= rd_ptr + 1'b1;
      if (rbeat.eop) begin
        pkt_cnt <= pkt_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_c3po_egress_sf.sv
// tb/tb_c3po_egress_sf.sv - directed self-checking bench for c3po_egress_sf
module tb_c3po_egress_sf;

  logic         clk;
  logic         reset_L;
  logic         in_val, in_sop, in_eop;
  logic [7:0]   in_vbc;
  logic [255:0] in_data;
  logic         out_val, out_sop, out_eop;
  logic [7:0]   out_vbc;
  logic [255:0] out_data;
  logic         out_ready;
  logic [7:0]   drop_cnt, pkt_cnt;
  logic         proto_err, idle;

  int total = 0;
  int bad   = 0;

  c3po_egress_sf #(.DEPTH_P(16), .CNT_SIZE_P(8)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .in_val    (in_val),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_vbc    (in_vbc),
    .in_data   (in_data),
    .out_val   (out_val),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_vbc   (out_vbc),
    .out_data  (out_data),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt),
    .pkt_cnt   (pkt_cnt),
    .proto_err (proto_err),
    .idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] dpat(input logic [31:0] n);
    return {8{n}};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic s, input logic e, input logic [7:0] v, input logic [255:0] d);
    in_val  = 1'b1;
    in_sop  = s;
    in_eop  = e;
    in_vbc  = v;
    in_data = d;
    @(posedge clk);
    #1;
    in_val = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
  endtask

  initial begin
    int  n;
    int  eop_at;
    logic seen_val;

    reset_L   = 1'b0;
    in_val    = 1'b0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    in_vbc    = 8'd0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_L = 1'b1;

    // reset state
    chk("rst_out_val",  256'(out_val),   256'(0));
    chk("rst_out_sop",  256'(out_sop),   256'(0));
    chk("rst_out_eop",  256'(out_eop),   256'(0));
    chk("rst_out_vbc",  256'(out_vbc),   256'(0));
    chk("rst_out_data", out_data,        256'(0));
    chk("rst_drop",     256'(drop_cnt),  256'(0));
    chk("rst_pkt",      256'(pkt_cnt),   256'(0));
    chk("rst_perr",     256'(proto_err), 256'(0));
    chk("rst_idle",     256'(idle),      256'(1));

    // 3-beat packet, sink always ready
    out_ready = 1'b1;
    send(1'b1, 1'b0, 8'd32, dpat(32'hA1));
    send(1'b0, 1'b0, 8'd32, dpat(32'hA2));
    chk("t1_hidden", 256'(out_val), 256'(0));
    send(1'b0, 1'b1, 8'd5, dpat(32'hA3));
    chk("t1_b0_val",  256'(out_val), 256'(1));
    chk("t1_b0_sop",  256'(out_sop), 256'(1));
    chk("t1_b0_vbc",  256'(out_vbc), 256'(32));
    chk("t1_b0_data", out_data,      dpat(32'hA1));
    @(posedge clk); #1;
    chk("t1_b1_vbc",  256'(out_vbc), 256'(32));
    chk("t1_b1_data", out_data,      dpat(32'hA2));
    @(posedge clk); #1;
    chk("t1_b2_vbc",  256'(out_vbc), 256'(5));
    chk("t1_b2_eop",  256'(out_eop), 256'(1));
    chk("t1_b2_data", out_data,      dpat(32'hA3));
    @(posedge clk); #1;
    chk("t1_empty", 256'(out_val), 256'(0));
    chk("t1_pkt",   256'(pkt_cnt), 256'(1));

    // 10-beat packet held, 8-beat packet overflows at its 7th beat
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++)
      send(i == 0, i == 9, 8'(i + 1), dpat(32'(32'h100 + i)));
    for (int i = 0; i < 8; i++)
      send(i == 0, i == 7, 8'd32, dpat(32'(32'h200 + i)));
    chk("t2_drop",     256'(drop_cnt), 256'(1));
    chk("t2_head_val", 256'(out_val),  256'(1));
    chk("t2_head_sop", 256'(out_sop),  256'(1));
    chk("t2_head_vbc", 256'(out_vbc),  256'(1));
    out_ready = 1'b1;
    n = 0;
    eop_at = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_val) begin
        n++;
        if (out_eop) eop_at = n;
      end
      @(posedge clk); #1;
    end
    chk("t2_beats",  256'(n),       256'(10));
    chk("t2_eop_at", 256'(eop_at),  256'(10));
    chk("t2_pkt",    256'(pkt_cnt), 256'(2));
    chk("t2_idle",   256'(idle),    256'(1));

    // 20-beat packet into an empty FIFO is dropped whole
    seen_val = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send(i == 0, i == 19, 8'd32, dpat(32'(32'h300 + i)));
      if (out_val) seen_val = 1'b1;
    end
    @(posedge clk); #1;
    if (out_val) seen_val = 1'b1;
    chk("t3_never_val", 256'(seen_val), 256'(0));
    chk("t3_drop",      256'(drop_cnt), 256'(2));
    chk("t3_idle",      256'(idle),     256'(1));
    chk("t3_pkt",       256'(pkt_cnt),  256'(2));

    // missing eop: the abandoned packet vanishes, the new 1-beat packet egresses
    out_ready = 1'b0;
    send(1'b1, 1'b0, 8'd32, dpat(32'h401));
    send(1'b0, 1'b0, 8'd32, dpat(32'h402));
    send(1'b1, 1'b1, 8'd7,  dpat(32'h403));
    chk("t4_perr",     256'(proto_err), 256'(1));
    chk("t4_val",      256'(out_val),   256'(1));
    chk("t4_sop",      256'(out_sop),   256'(1));
    chk("t4_eop",      256'(out_eop),   256'(1));
    chk("t4_vbc",      256'(out_vbc),   256'(7));
    chk("t4_data",     out_data,        dpat(32'h403));
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_perr_off", 256'(proto_err), 256'(0));
    chk("t4_empty",    256'(out_val),   256'(0));
    chk("t4_pkt",      256'(pkt_cnt),   256'(3));

    // stray mid-packet beat in IDLE
    send(1'b0, 1'b0, 8'd32, dpat(32'h501));
    chk("t5_perr", 256'(proto_err), 256'(1));
    chk("t5_val",  256'(out_val),   256'(0));
    chk("t5_idle", 256'(idle),      256'(1));
    @(posedge clk); #1;
    chk("t5_val2", 256'(out_val),   256'(0));

    // async reset during 2nd beat of a 4-beat packet
    send(1'b1, 1'b0, 8'd32, dpat(32'h601));
    in_val  = 1'b1;
    in_sop  = 1'b0;
    in_eop  = 1'b0;
    in_vbc  = 8'd32;
    in_data = dpat(32'h602);
    #3;
    reset_L = 1'b0;
    #1;
    chk("t6_val",  256'(out_val),  256'(0));
    chk("t6_data", out_data,       256'(0));
    chk("t6_drop", 256'(drop_cnt), 256'(0));
    chk("t6_pkt",  256'(pkt_cnt),  256'(0));
    chk("t6_idle", 256'(idle),     256'(1));
    in_val = 1'b0;
    @(posedge clk); #1;
    reset_L = 1'b1;
    out_ready = 1'b0;
    send(1'b1, 1'b1, 8'd9, dpat(32'h701));
    chk("t6_new_val",  256'(out_val), 256'(1));
    chk("t6_new_vbc",  256'(out_vbc), 256'(9));
    chk("t6_new_data", out_data,      dpat(32'h701));
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t6_new_pkt",  256'(pkt_cnt), 256'(1));
    chk("t6_new_done", 256'(out_val), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
